// File: rtl/brtag_alloc.sv
// -----------------------------------------------------------------------------
// brtag_alloc
//
// Branch-tag allocator and resolution receiver for the speculative pipeline.
// Dispatching branch/jump instructions receive sequential tags from a ring of
// N = 2**WIDTH_BRM entries. Resolutions from the branch unit retire the oldest
// tag. A mispredict kill rolls the ring back to the tag following the killed
// branch. It also produces a one-cycle fetch redirect and flush pulse, and
// blocks allocation for one recovery cycle.
//
// Ports
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_alloc     : dispatching branch requests a tag
//   i_brmask    : {en, mask}; en marks a kill, mask is the rollback tag
//   i_brkill    : mispredict kill from the branch unit
//   i_PC        : corrected target PC (valid with a kill)
//   i_valid     : a branch resolved this cycle
//   o_tag       : tag granted to the current i_alloc (from alloc pointer)
//   o_stall     : allocation refused this cycle (combinational)
//   o_count     : outstanding tags, 0..N
//   o_redirect  : one-cycle fetch redirect pulse (registered)
//   o_PC        : redirect PC (registered)
//   o_err       : sticky protocol-violation flag, only with BRTAG_CHECK_EN
//   o_flush     : one-cycle squash pulse (registered)
//
// Optional feature macro: BRTAG_CHECK_EN (adds o_err and its checking logic).
// -----------------------------------------------------------------------------
module brtag_alloc #(
  parameter int WIDTH_BRM = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc,
  input  logic [WIDTH_BRM:0]   i_brmask,
  input  logic                 i_brkill,
  input  logic [31:0]          i_PC,
  input  logic                 i_valid,
  output logic [WIDTH_BRM-1:0] o_tag,
  output logic                 o_stall,
  output logic [WIDTH_BRM:0]   o_count,
  output logic                 o_redirect,
  output logic [31:0]          o_PC,
`ifdef BRTAG_CHECK_EN
  output logic                 o_err,
`endif
  output logic                 o_flush
);

  localparam int unsigned             N_TAGS   = 2 ** WIDTH_BRM;
  localparam logic [WIDTH_BRM:0]      FULL_CNT = N_TAGS[WIDTH_BRM:0];
  localparam logic [WIDTH_BRM:0]      ZERO_CNT = '0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  // Ring pointer advance; wraps from N-1 to 0 by natural overflow.
  function automatic logic [WIDTH_BRM-1:0] ptr_inc(input logic [WIDTH_BRM-1:0] p);
    ptr_inc = p + {{(WIDTH_BRM-1){1'b0}}, 1'b1};
  endfunction

  state_t                 state_q, state_d;
  logic [WIDTH_BRM-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [WIDTH_BRM-1:0]   free_ptr_q, free_ptr_d;
  logic [WIDTH_BRM:0]     count_q, count_d;
  logic                   redirect_q, redirect_d;
  logic                   flush_q, flush_d;
  logic [31:0]            pc_q, pc_d;

  logic                   kill_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   stall_s;
  logic                   grant_s;
  logic                   resolve_s;

  // Request qualification: kill, stall, grant and resolve strobes.
  always_comb begin
    kill_s    = i_brkill | i_brmask[WIDTH_BRM];
    full_s    = (count_q == FULL_CNT);
    empty_s   = (count_q == ZERO_CNT);
    // A kill stalls in its own cycle so a coincident i_alloc is dropped.
    stall_s   = full_s | (state_q == ST_RECOVER) | kill_s;
    grant_s   = i_alloc & ~stall_s;
    resolve_s = i_valid & ~kill_s & ~empty_s;
  end

  // Pointer, count and redirect next-state; kill overrides grant/resolve.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    free_ptr_d  = free_ptr_q;
    count_d     = count_q;
    pc_d        = pc_q;
    redirect_d  = 1'b0;
    flush_d     = 1'b0;
    if (kill_s) begin
      // Branches resolve in order, so the killed branch is the oldest tag
      // and nothing younger survives: the ring empties at the mask.
      alloc_ptr_d = i_brmask[WIDTH_BRM-1:0];
      free_ptr_d  = i_brmask[WIDTH_BRM-1:0];
      count_d     = ZERO_CNT;
      pc_d        = i_PC;
      redirect_d  = 1'b1;
      flush_d     = 1'b1;
    end else begin
      if (grant_s) begin
        alloc_ptr_d = ptr_inc(alloc_ptr_q);
      end else begin
        alloc_ptr_d = alloc_ptr_q;
      end
      if (resolve_s) begin
        free_ptr_d = ptr_inc(free_ptr_q);
      end else begin
        free_ptr_d = free_ptr_q;
      end
      case ({grant_s, resolve_s})
        2'b10:   count_d = count_q + {{WIDTH_BRM{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{WIDTH_BRM{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Recovery FSM: one RECOVER cycle after each kill, re-armed by a new kill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (kill_s) begin
          state_d = ST_RECOVER;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RECOVER: begin
        if (kill_s) begin
          state_d = ST_RECOVER;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      alloc_ptr_q <= '0;
      free_ptr_q  <= '0;
      count_q     <= '0;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      pc_q        <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      alloc_ptr_q <= alloc_ptr_d;
      free_ptr_q  <= free_ptr_d;
      count_q     <= count_d;
      redirect_q  <= redirect_d;
      flush_q     <= flush_d;
      pc_q        <= pc_d;
    end
  end

`ifdef BRTAG_CHECK_EN
  logic err_q, err_d;

  // Sticky protocol-violation detection.
  always_comb begin
    err_d = err_q;
    if (kill_s && (i_brmask[WIDTH_BRM-1:0] != ptr_inc(free_ptr_q))) begin
      err_d = 1'b1;
    end else if (i_valid && !kill_s && empty_s) begin
      err_d = 1'b1;
    end else if (i_alloc && full_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

  assign o_tag      = alloc_ptr_q;
  assign o_stall    = stall_s;
  assign o_count    = count_q;
  assign o_redirect = redirect_q;
  assign o_flush    = flush_q;
  assign o_PC       = pc_q;

endmodule

// File: tb/tb_brtag_alloc.sv
// -----------------------------------------------------------------------------
// tb_brtag_alloc
//
// Self-checking bench for brtag_alloc (default build, BRTAG_CHECK_EN off).
// The reference model keeps outstanding tags in a queue: grants push the next
// sequential tag, resolutions pop the oldest, a kill empties the queue and
// restarts numbering at the mask.
// -----------------------------------------------------------------------------
module tb_brtag_alloc;

  localparam int W = 4;
  localparam int N = 16;

  logic          clk;
  logic          rst_n;
  logic          alloc;
  logic [W:0]    brmask;
  logic          brkill;
  logic [31:0]   pc_in;
  logic          valid;
  logic [W-1:0]  o_tag;
  logic          o_stall;
  logic [W:0]    o_count;
  logic          o_redirect;
  logic [31:0]   o_PC;
  logic          o_flush;

  brtag_alloc #(.WIDTH_BRM(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_alloc    (alloc),
    .i_brmask   (brmask),
    .i_brkill   (brkill),
    .i_PC       (pc_in),
    .i_valid    (valid),
    .o_tag      (o_tag),
    .o_stall    (o_stall),
    .o_count    (o_count),
    .o_redirect (o_redirect),
    .o_PC       (o_PC),
    .o_flush    (o_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_q[$];
  int          m_next_tag;
  bit          m_recover;
  bit          m_redirect;
  bit          m_flush;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next_tag = 0;
    m_recover  = 1'b0;
    m_redirect = 1'b0;
    m_flush    = 1'b0;
    m_pc       = 32'h0;
  endtask

  function automatic bit model_kill();
    return brkill || brmask[W];
  endfunction

  function automatic bit model_stall();
    return (m_q.size() == N) || m_recover || model_kill();
  endfunction

  task automatic compare_all(input string ctx);
    check({ctx, ".tag"},      32'(o_tag),      32'(m_next_tag));
    check({ctx, ".stall"},    32'(o_stall),    32'(model_stall()));
    check({ctx, ".count"},    32'(o_count),    32'(m_q.size()));
    check({ctx, ".redirect"}, 32'(o_redirect), 32'(m_redirect));
    check({ctx, ".flush"},    32'(o_flush),    32'(m_flush));
    check({ctx, ".pc"},       o_PC,            m_pc);
  endtask

  task automatic model_step();
    if (model_kill()) begin
      m_q.delete();
      m_next_tag = int'(brmask[W-1:0]);
      m_recover  = 1'b1;
      m_redirect = 1'b1;
      m_flush    = 1'b1;
      m_pc       = pc_in;
    end else begin
      bit do_grant;
      do_grant = alloc && !model_stall();
      if (valid && m_q.size() != 0) void'(m_q.pop_front());
      if (do_grant) begin
        m_q.push_back(m_next_tag);
        m_next_tag = (m_next_tag + 1) % N;
      end
      m_recover  = 1'b0;
      m_redirect = 1'b0;
      m_flush    = 1'b0;
    end
  endtask

  // One clock cycle: drive at negedge, check just after, advance model at posedge.
  task automatic cycle(input string ctx, input bit a, input bit v, input bit k,
                       input logic [W:0] m, input logic [31:0] p);
    @(negedge clk);
    alloc  = a;
    valid  = v;
    brkill = k;
    brmask = m;
    pc_in  = p;
    #1;
    compare_all(ctx);
    model_step();
    @(posedge clk);
  endtask

  task automatic apply_reset(input string ctx);
    @(negedge clk);
    alloc  = 1'b0;
    valid  = 1'b0;
    brkill = 1'b0;
    brmask = '0;
    pc_in  = 32'h0;
    rst_n  = 1'b0;
    #1;
    model_reset();
    compare_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    alloc  = 1'b0;
    valid  = 1'b0;
    brkill = 1'b0;
    brmask = '0;
    pc_in  = 32'h0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three back-to-back grants: tags 0,1,2 then count 3
    for (int i = 0; i < 3; i++) cycle("seq3", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("seq3_idle", 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);

    // Fill to N, refused 17th, resolve at full, then alloc+resolve
    apply_reset("reset_fill");
    for (int i = 0; i < N; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("full_alloc", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("full_alloc_valid", 1'b1, 1'b1, 1'b0, 5'h00, 32'h0);
    cycle("alloc_valid", 1'b1, 1'b1, 1'b0, 5'h00, 32'h0);
    cycle("after_full", 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);

    // Kill with two tags outstanding
    apply_reset("reset_kill");
    cycle("k_alloc", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("k_alloc", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("kill", 1'b0, 1'b0, 1'b1, 5'h11, 32'h0000_0080);
    cycle("recover", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("resume", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("resume_idle", 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);

    // Kill via mask enable coincident with alloc, then kill during RECOVER
    cycle("kill_alloc", 1'b1, 1'b1, 1'b0, 5'h15, 32'h0000_1234);
    cycle("kill_in_recover", 1'b1, 1'b0, 1'b1, 5'h07, 32'h0000_5678);
    cycle("recover2", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("resume2", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);

    // Resolve on empty ring is ignored
    apply_reset("reset_empty");
    cycle("empty_valid", 1'b0, 1'b1, 1'b0, 5'h00, 32'h0);
    cycle("empty_after", 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);

    // Reset asserted in the RECOVER cycle
    cycle("pre_kill", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("kill_then_rst", 1'b0, 1'b0, 1'b1, 5'h19, 32'hDEAD_BEEF);
    apply_reset("reset_in_recover");
    cycle("run_after_rst", 1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
    cycle("run_after_rst2", 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          a, v, k;
      logic [W:0]  m;
      logic [31:0] p;
      int          r;
      a = ($urandom_range(0, 99) < 65);
      v = ($urandom_range(0, 99) < 45);
      r = $urandom_range(0, 99);
      k = (r < 3);
      m = 5'($urandom_range(0, 15));
      if (r >= 3 && r < 6) m[W] = 1'b1;
      else                 m[W] = 1'b0;
      p = $urandom();
      cycle("rand", a, v, k, m, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
